vlsu_txn_tracker: RTL and testbench

Parametrised outstanding-transaction tracker for the vector load/store unit's AXI port. It generalises the single-cycle registering of load/store element width into per-burst sideband queues, one for reads and one for writes, each `Depth` entries deep. Sideband (element width, vl slice, instruction id) is captured on each AR/AW handshake and presented to the load/store units when the matching R/B response arrives. It sits between the address generator and the AXI cut, and throttles address issue when a queue is full.

---
 rtl/vlsu_txn_tracker.sv | 109 ++++++++++
 tb/tb_vlsu_txn_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vlsu_txn_tracker.sv
// vlsu_txn_tracker: per-burst AR/AW sideband queues; VLSU_TRACKER_ERR_EN enables sticky underflow flags on error_o.
module vlsu_txn_queue #(
   parameter int Depth = 8,
   parameter int SideW = 16,
   parameter int CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [SideW-1:0] side_i,
   output logic             full_o,
   output logic [SideW-1:0] side_o,
   output logic             side_valid_o,
   output logic [CntW-1:0]  cnt_o
);
   localparam int PtrW = $clog2(Depth);
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [SideW-1:0] mem_q [Depth];
   logic             pop_ok;
   always_comb begin
      pop_ok   = pop_i & (cnt_q != '0);
      wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CntW'(push_i) - CntW'(pop_ok);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= side_i;
   end
   assign full_o       = cnt_q == CntW'(Depth);
   assign side_valid_o = cnt_q != '0;
   assign side_o       = side_valid_o ? mem_q[rd_ptr_q] : '0;
   assign cnt_o        = cnt_q;
endmodule

module vlsu_txn_tracker #(
   parameter int Depth = 8,
   parameter int SideW = 16,
   parameter int CntW  = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ar_valid_i,
   output logic             ar_ready_o,
   input  logic [SideW-1:0] ar_side_i,
   output logic             ar_valid_o,
   input  logic             ar_ready_i,
   input  logic             r_valid_i,
   input  logic             r_ready_i,
   input  logic             r_last_i,
   output logic [SideW-1:0] r_side_o,
   output logic             r_side_valid_o,
   input  logic             aw_valid_i,
   output logic             aw_ready_o,
   input  logic [SideW-1:0] aw_side_i,
   output logic             aw_valid_o,
   input  logic             aw_ready_i,
   input  logic             b_valid_i,
   input  logic             b_ready_i,
   output logic [SideW-1:0] w_side_o,
   output logic             w_side_valid_o,
   output logic [CntW-1:0]  rd_outstanding_o,
   output logic [CntW-1:0]  wr_outstanding_o,
   output logic [1:0]       error_o
);
   logic rd_full, wr_full, rd_push, wr_push, rd_pop, wr_pop;
   // Gating valid as well as ready keeps AXI valid stable: full is only left by a pop.
   assign ar_ready_o = ar_ready_i & ~rd_full;
   assign ar_valid_o = ar_valid_i & ~rd_full;
   assign aw_ready_o = aw_ready_i & ~wr_full;
   assign aw_valid_o = aw_valid_i & ~wr_full;
   assign rd_push    = ar_valid_o & ar_ready_i;
   assign wr_push    = aw_valid_o & aw_ready_i;
   assign rd_pop     = r_valid_i & r_ready_i & r_last_i;
   assign wr_pop     = b_valid_i & b_ready_i;

   vlsu_txn_queue #(.Depth(Depth), .SideW(SideW), .CntW(CntW)) u_rd_q (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(rd_push), .pop_i(rd_pop), .side_i(ar_side_i),
      .full_o(rd_full), .side_o(r_side_o), .side_valid_o(r_side_valid_o), .cnt_o(rd_outstanding_o)
   );
   vlsu_txn_queue #(.Depth(Depth), .SideW(SideW), .CntW(CntW)) u_wr_q (
      .clk_i(clk_i), .rst_i(rst_i), .push_i(wr_push), .pop_i(wr_pop), .side_i(aw_side_i),
      .full_o(wr_full), .side_o(w_side_o), .side_valid_o(w_side_valid_o), .cnt_o(wr_outstanding_o)
   );

`ifdef VLSU_TRACKER_ERR_EN
   logic [1:0] err_q, err_d;
   always_comb err_d = err_q | {wr_pop & ~w_side_valid_o, rd_pop & ~r_side_valid_o};
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= '0;
      else       err_q <= err_d;
   end
   assign error_o = err_q;
`else
   assign error_o = 2'b00;
`endif
endmodule

// File: tb/tb_vlsu_txn_tracker.sv
// tb_vlsu_txn_tracker: directed checks of the read/write sideband queues at Depth=8.
module tb_vlsu_txn_tracker;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        ar_valid_i = 0, ar_ready_i = 0, r_valid_i = 0, r_ready_i = 0, r_last_i = 0;
   logic        aw_valid_i = 0, aw_ready_i = 0, b_valid_i = 0, b_ready_i = 0;
   logic [15:0] ar_side_i = '0, aw_side_i = '0;
   logic        ar_ready_o, ar_valid_o, aw_ready_o, aw_valid_o, r_side_valid_o, w_side_valid_o;
   logic [15:0] r_side_o, w_side_o;
   logic [3:0]  rd_outstanding_o, wr_outstanding_o;
   logic [1:0]  error_o;
   int          n_cmp = 0, n_err = 0;
`ifdef VLSU_TRACKER_ERR_EN
   localparam logic [1:0] WrErr = 2'b10;
`else
   localparam logic [1:0] WrErr = 2'b00;
`endif

   vlsu_txn_tracker #(.Depth(8), .SideW(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_side_i(ar_side_i),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
      .r_side_o(r_side_o), .r_side_valid_o(r_side_valid_o),
      .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_side_i(aw_side_i),
      .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
      .w_side_o(w_side_o), .w_side_valid_o(w_side_valid_o),
      .rd_outstanding_o(rd_outstanding_o), .wr_outstanding_o(wr_outstanding_o),
      .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_rpop(input logic v);
      r_valid_i = v;
      r_ready_i = v;
      r_last_i  = v;
   endtask

   initial begin
      repeat (2) step();
      check("rst_cnt", 32'(rd_outstanding_o), 0);
      check("rst_vld", 32'(r_side_valid_o), 0);
      check("rst_side", 32'(r_side_o), 0);
      check("rst_err", 32'(error_o), 0);
      rst_i = 0;
      step();
      // three ARs then three last beats, in order
      ar_valid_i = 1; ar_ready_i = 1; ar_side_i = 16'h11;
      step();
      check("vis_side", 32'(r_side_o), 32'h11);
      check("vis_vld", 32'(r_side_valid_o), 1);
      ar_side_i = 16'h22; step();
      ar_side_i = 16'h33; step();
      ar_valid_i = 0;
      check("ord_cnt3", 32'(rd_outstanding_o), 3);
      check("ord_h0", 32'(r_side_o), 32'h11);
      set_rpop(1);
      step();
      check("ord_h1", 32'(r_side_o), 32'h22);
      check("ord_cnt2", 32'(rd_outstanding_o), 2);
      step();
      check("ord_h2", 32'(r_side_o), 32'h33);
      step();
      set_rpop(0);
      check("ord_cnt0", 32'(rd_outstanding_o), 0);
      check("ord_empty", 32'(r_side_valid_o), 0);
      check("ord_zero", 32'(r_side_o), 0);
      // fill to Depth
      ar_valid_i = 1;
      for (int i = 0; i < 8; i++) begin
         ar_side_i = 16'(16'h100 + i);
         step();
      end
      ar_side_i = 16'h200;
      check("full_cnt", 32'(rd_outstanding_o), 8);
      check("full_rdy", 32'(ar_ready_o), 0);
      check("full_vld", 32'(ar_valid_o), 0);
      set_rpop(1);
      step();
      check("full_pop_cnt", 32'(rd_outstanding_o), 7);
      check("full_pop_head", 32'(r_side_o), 32'h101);
      check("full_rdy_back", 32'(ar_ready_o), 1);
      check("full_vld_back", 32'(ar_valid_o), 1);
      step();
      ar_valid_i = 0;
      check("pp_cnt", 32'(rd_outstanding_o), 7);
      check("pp_head", 32'(r_side_o), 32'h102);
      for (int i = 0; i < 7; i++) begin
         check("drain", 32'(r_side_o), (i < 6) ? 32'h102 + 32'(i) : 32'h200);
         step();
      end
      set_rpop(0);
      check("drain_cnt", 32'(rd_outstanding_o), 0);
      check("rd_no_err", 32'(error_o), 0);
      // multi-beat burst: only the last beat pops
      ar_valid_i = 1; ar_side_i = 16'h44; step();
      ar_side_i = 16'h55; step();
      ar_valid_i = 0;
      r_valid_i = 1; r_ready_i = 1; r_last_i = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("burst_hold", 32'(r_side_o), 32'h44);
      end
      r_last_i = 1;
      step();
      check("burst_adv", 32'(r_side_o), 32'h55);
      check("burst_cnt", 32'(rd_outstanding_o), 1);
      step();
      set_rpop(0);
      check("burst_empty", 32'(rd_outstanding_o), 0);
      // write queue basic and underflow
      aw_valid_i = 1; aw_ready_i = 1; aw_side_i = 16'hA1;
      step();
      aw_valid_i = 0;
      check("w_side", 32'(w_side_o), 32'hA1);
      check("w_vld", 32'(w_side_valid_o), 1);
      check("w_cnt1", 32'(wr_outstanding_o), 1);
      b_valid_i = 1; b_ready_i = 1;
      step();
      check("w_cnt0", 32'(wr_outstanding_o), 0);
      check("w_no_err", 32'(error_o), 0);
      step();
      b_valid_i = 0; b_ready_i = 0;
      check("uf_err", 32'(error_o), 32'(WrErr));
      check("uf_cnt", 32'(wr_outstanding_o), 0);
      check("uf_rcnt", 32'(rd_outstanding_o), 0);
      step();
      check("uf_sticky", 32'(error_o), 32'(WrErr));
      // async reset with five outstanding
      ar_valid_i = 1;
      for (int i = 0; i < 5; i++) begin
         ar_side_i = 16'(16'h60 + i);
         step();
      end
      ar_valid_i = 0; ar_ready_i = 0; aw_ready_i = 0;
      check("pre_rst_cnt", 32'(rd_outstanding_o), 5);
      #2 rst_i = 1;
      #1;
      check("arst_cnt", 32'(rd_outstanding_o), 0);
      check("arst_vld", 32'(r_side_valid_o), 0);
      check("arst_side", 32'(r_side_o), 0);
      check("arst_err", 32'(error_o), 0);
      check("arst_rdy", 32'(ar_ready_o), 0);
      step();
      rst_i = 0;
      step();
      check("post_rst_cnt", 32'(rd_outstanding_o), 0);
      check("post_rst_vld", 32'(r_side_valid_o), 0);
      // wrap-around
      ar_ready_i = 1;
      for (int i = 0; i < 20; i++) begin
         ar_valid_i = 1; ar_side_i = 16'(16'h300 + i);
         step();
         ar_valid_i = 0;
         check("wrap_head", 32'(r_side_o), 32'h300 + 32'(i));
         set_rpop(1);
         step();
         set_rpop(0);
         check("wrap_cnt", 32'(rd_outstanding_o), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
